serial_byte_feeder: RTL and testbench

Parallel-to-serial feeder that buffers bytes from the fabric and emits them one bit per clock, LSB first, with a first-bit strobe. It sits directly upstream of the serial writer stage. `bit_o` drives that stage's serial data input and `next_byte_o` drives its `next_byte` input, so the writer's bit counter stays aligned to byte boundaries. Back-to-back bytes stream with no idle cycles between them.

---
 rtl/serial_byte_feeder.sv | 65 ++++++
 tb/tb_serial_byte_feeder.sv | 284 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/serial_byte_feeder.sv
// serial_byte_feeder: FIFO-buffered byte to LSB-first serial bit stream with first-bit strobe
module serial_byte_feeder #(
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [7:0]               in_data,
  input  logic                     in_valid,
  output logic                     in_ready,
  output logic                     bit_o,
  output logic                     next_byte_o,
  output logic [2:0]               bit_count_o,
  output logic                     busy_o,
  output logic [$clog2(DEPTH):0]   level_o
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL = (AW+1)'(DEPTH);
  typedef enum logic {IDLE, SHIFT} state_t;
  state_t state;
  logic [7:0] mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [7:0] shreg;
  logic push, load;
  assign in_ready = level_o != FULL;
  assign push = in_valid && in_ready;
  assign load = level_o != '0 && (state == IDLE || bit_count_o == 3'd7);
  always_ff @(posedge clk)
    if (push) mem[wr_ptr] <= in_data;
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      level_o     <= '0;
      shreg       <= '0;
      bit_o       <= 1'b0;
      next_byte_o <= 1'b0;
      bit_count_o <= '0;
      busy_o      <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (load) rd_ptr <= rd_ptr + AW'(1);
      level_o <= level_o + (AW+1)'(push) - (AW+1)'(load);
      if (load) begin
        state       <= SHIFT;
        shreg       <= mem[rd_ptr];
        bit_o       <= mem[rd_ptr][0];
        next_byte_o <= 1'b1;
        bit_count_o <= '0;
        busy_o      <= 1'b1;
      end else if (state == SHIFT && bit_count_o != 3'd7) begin
        shreg       <= shreg >> 1;
        bit_o       <= shreg[1];
        next_byte_o <= 1'b0;
        bit_count_o <= bit_count_o + 3'd1;
      end else begin
        state       <= IDLE;
        bit_o       <= 1'b0;
        next_byte_o <= 1'b0;
        bit_count_o <= '0;
        busy_o      <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_serial_byte_feeder.sv
// tb_serial_byte_feeder: directed and random self-checking bench for serial_byte_feeder
module tb_serial_byte_feeder;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [7:0] in_data = '0;
  logic in_valid = 1'b0;
  logic in_ready, bit_o, next_byte_o, busy_o;
  logic [2:0] bit_count_o;
  logic [2:0] level_o;
  int checks = 0;
  int failures = 0;
  logic [7:0] cur;
  logic [7:0] got [$];
  int nb_cnt;
  serial_byte_feeder #(.DEPTH(4)) dut (
    .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .bit_o(bit_o), .next_byte_o(next_byte_o), .bit_count_o(bit_count_o), .busy_o(busy_o),
    .level_o(level_o)
  );
  always #5 clk = ~clk;
  task automatic tick();
    @(negedge clk);
    if (busy_o) begin
      cur[bit_count_o] = bit_o;
      if (bit_count_o == 3'd7) got.push_back(cur);
    end
    if (next_byte_o) nb_cnt++;
  endtask
  task automatic do_reset();
    rst = 1'b1;
    in_valid = 1'b0;
    tick();
    rst = 1'b0;
    got.delete();
    nb_cnt = 0;
  endtask
  task automatic test_reset();
    rst = 1'b1;
    in_valid = 1'b1;
    in_data = 8'hFF;
    tick();
    tick();
    rst = 1'b0;
    in_valid = 1'b0;
    checks++;
    if ({bit_o, next_byte_o, bit_count_o, busy_o} !== 6'b0) begin
      failures++;
      $display("FAIL reset_outputs got=%b exp=000000", {bit_o, next_byte_o, bit_count_o, busy_o});
    end
    checks++;
    if (level_o !== 3'd0 || in_ready !== 1'b1) begin
      failures++;
      $display("FAIL reset_level got level=%0d ready=%b exp level=0 ready=1", level_o, in_ready);
    end
    tick();
    checks++;
    if (level_o !== 3'd0 || busy_o !== 1'b0) begin
      failures++;
      $display("FAIL reset_push_discard got level=%0d busy=%b exp level=0 busy=0", level_o, busy_o);
    end
  endtask
  task automatic test_single();
    logic exp_bits [8] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
    do_reset();
    for (int k = 0; k <= 10; k++) begin
      if (k == 1) begin
        checks++;
        if (level_o !== 3'd1 || busy_o !== 1'b0) begin
          failures++;
          $display("FAIL single_latency got level=%0d busy=%b exp level=1 busy=0", level_o, busy_o);
        end
      end
      if (k >= 2 && k <= 9) begin
        checks++;
        if (bit_o !== exp_bits[k-2] || next_byte_o !== (k == 2) || bit_count_o !== 3'(k-2) || busy_o !== 1'b1) begin
          failures++;
          $display("FAIL single_bit%0d got bit=%b nb=%b cnt=%0d busy=%b exp bit=%b nb=%b cnt=%0d busy=1",
                   k-2, bit_o, next_byte_o, bit_count_o, busy_o, exp_bits[k-2], k == 2, k-2);
        end
      end
      if (k == 10) begin
        checks++;
        if (busy_o !== 1'b0 || bit_o !== 1'b0 || next_byte_o !== 1'b0 || bit_count_o !== 3'd0) begin
          failures++;
          $display("FAIL single_end got busy=%b bit=%b nb=%b cnt=%0d exp all 0", busy_o, bit_o, next_byte_o, bit_count_o);
        end
      end
      in_valid = (k == 0);
      in_data = 8'hA5;
      tick();
    end
  endtask
  task automatic test_back_to_back();
    logic [23:0] stream = 24'hFF8001;
    int bad = 0;
    do_reset();
    for (int k = 0; k <= 26; k++) begin
      if (k >= 2 && k <= 25) begin
        if (bit_o !== stream[k-2] || next_byte_o !== ((k-2) % 8 == 0) || busy_o !== 1'b1) begin
          bad++;
          $display("FAIL b2b_bit%0d got bit=%b nb=%b busy=%b exp bit=%b nb=%b busy=1",
                   k-2, bit_o, next_byte_o, busy_o, stream[k-2], (k-2) % 8 == 0);
        end
      end
      if (k == 26) begin
        checks++;
        if (busy_o !== 1'b0 || bit_o !== 1'b0) begin
          failures++;
          $display("FAIL b2b_end got busy=%b bit=%b exp busy=0 bit=0", busy_o, bit_o);
        end
      end
      in_valid = (k < 3);
      in_data = k == 0 ? 8'h01 : k == 1 ? 8'h80 : 8'hFF;
      tick();
    end
    checks++;
    if (bad != 0) begin
      failures++;
      $display("FAIL b2b_stream got bad_bits=%0d exp 0", bad);
    end
    checks++;
    if (nb_cnt !== 3) begin
      failures++;
      $display("FAIL b2b_strobes got=%0d exp=3", nb_cnt);
    end
  endtask
  task automatic test_fill();
    logic [7:0] exp_bytes [5] = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55};
    int sent = 0;
    int n = 0;
    do_reset();
    in_valid = 1'b1;
    in_data = 8'h11;
    while (n < 20) begin
      if (in_valid && in_ready) sent++;
      tick();
      n++;
      in_data = in_data + 8'h11;
      if (!in_ready) break;
    end
    in_valid = 1'b0;
    checks++;
    if (level_o !== 3'd4 || in_ready !== 1'b0) begin
      failures++;
      $display("FAIL fill_full got level=%0d ready=%b exp level=4 ready=0", level_o, in_ready);
    end
    checks++;
    if (sent !== 5) begin
      failures++;
      $display("FAIL fill_accepted got=%0d exp=5", sent);
    end
    n = 0;
    while (n < 100 && (got.size() < 5 || busy_o)) begin
      tick();
      n++;
    end
    for (int i = 0; i < 10; i++) tick();
    checks++;
    if (got.size() !== 5) begin
      failures++;
      $display("FAIL fill_count got=%0d exp=5", got.size());
    end
    for (int i = 0; i < 5 && i < got.size(); i++) begin
      checks++;
      if (got[i] !== exp_bytes[i]) begin
        failures++;
        $display("FAIL fill_byte%0d got=%h exp=%h", i, got[i], exp_bytes[i]);
      end
    end
  endtask
  task automatic test_gap();
    do_reset();
    for (int k = 0; k <= 11; k++) begin
      if (k == 9) begin
        checks++;
        if (bit_count_o !== 3'd7 || bit_o !== 1'b0 || level_o !== 3'd0 || busy_o !== 1'b1) begin
          failures++;
          $display("FAIL gap_bit7 got cnt=%0d bit=%b level=%0d busy=%b exp cnt=7 bit=0 level=0 busy=1",
                   bit_count_o, bit_o, level_o, busy_o);
        end
      end
      if (k == 10) begin
        checks++;
        if (busy_o !== 1'b0 || bit_o !== 1'b0 || level_o !== 3'd1) begin
          failures++;
          $display("FAIL gap_idle got busy=%b bit=%b level=%0d exp busy=0 bit=0 level=1", busy_o, bit_o, level_o);
        end
      end
      if (k == 11) begin
        checks++;
        if (next_byte_o !== 1'b1 || busy_o !== 1'b1 || bit_o !== 1'b1 || bit_count_o !== 3'd0) begin
          failures++;
          $display("FAIL gap_restart got nb=%b busy=%b bit=%b cnt=%0d exp nb=1 busy=1 bit=1 cnt=0",
                   next_byte_o, busy_o, bit_o, bit_count_o);
        end
      end
      in_valid = (k == 0 || k == 9);
      in_data = k == 0 ? 8'h3C : 8'hC3;
      tick();
    end
    in_valid = 1'b0;
  endtask
  task automatic test_rst_mid();
    int bad = 0;
    do_reset();
    for (int k = 0; k <= 5; k++) begin
      if (k == 5) begin
        checks++;
        if (bit_count_o !== 3'd3 || level_o !== 3'd2 || busy_o !== 1'b1) begin
          failures++;
          $display("FAIL rstmid_pre got cnt=%0d level=%0d busy=%b exp cnt=3 level=2 busy=1", bit_count_o, level_o, busy_o);
        end
      end
      in_valid = (k < 3);
      in_data = 8'hF0 + 8'(k);
      rst = (k == 5);
      tick();
    end
    rst = 1'b0;
    checks++;
    if ({bit_o, next_byte_o, bit_count_o, busy_o} !== 6'b0 || level_o !== 3'd0 || in_ready !== 1'b1) begin
      failures++;
      $display("FAIL rstmid_post got outs=%b level=%0d ready=%b exp outs=000000 level=0 ready=1",
               {bit_o, next_byte_o, bit_count_o, busy_o}, level_o, in_ready);
    end
    for (int i = 0; i < 12; i++) begin
      tick();
      if (busy_o !== 1'b0 || bit_o !== 1'b0 || next_byte_o !== 1'b0) bad++;
    end
    checks++;
    if (bad != 0) begin
      failures++;
      $display("FAIL rstmid_silent got active_cycles=%0d exp 0", bad);
    end
  endtask
  task automatic test_random();
    logic [7:0] exp_q [$];
    int n = 0;
    int bad = 0;
    do_reset();
    for (int k = 0; k < 1000; k++) begin
      in_valid = $urandom_range(0, 3) != 0;
      in_data = 8'($urandom);
      if (in_valid && in_ready) exp_q.push_back(in_data);
      tick();
    end
    in_valid = 1'b0;
    while (n < 300 && (got.size() < exp_q.size() || busy_o)) begin
      tick();
      n++;
    end
    checks++;
    if (got.size() !== exp_q.size()) begin
      failures++;
      $display("FAIL rand_count got=%0d exp=%0d", got.size(), exp_q.size());
    end
    for (int i = 0; i < exp_q.size() && i < got.size(); i++)
      if (got[i] !== exp_q[i]) begin
        if (bad < 5) $display("FAIL rand_byte%0d got=%h exp=%h", i, got[i], exp_q[i]);
        bad++;
      end
    checks++;
    if (bad != 0) begin
      failures++;
      $display("FAIL rand_data got bad_bytes=%0d exp 0", bad);
    end
    checks++;
    if (nb_cnt !== exp_q.size()) begin
      failures++;
      $display("FAIL rand_strobes got=%0d exp=%0d", nb_cnt, exp_q.size());
    end
  endtask
  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_fill();
    test_gap();
    test_rst_mid();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
